// File: rtl/store_write_buffer_pkg.sv
// Shared types and sizes for the posted-store buffer.
// Entries hold a word address and the store data.
package store_write_buffer_pkg;

  localparam int SB_DEPTH = 4;
  localparam int SB_AW    = 32;
  localparam int SB_DW    = 32;

  typedef struct packed {
    logic [SB_AW-3:0] wadr;
    logic [SB_DW-1:0] data;
  } sb_entry_t;

endpackage

// File: rtl/store_write_buffer_fwd_match.sv
// Load-forwarding lookup: compares a word address against the live
// entries and picks the youngest match.
module sb_fwd_match #(
  parameter int DEPTH = 4,
  parameter int AW    = 32,
  localparam int PW   = $clog2(DEPTH)
) (
  input  logic [AW-3:0] key,
  input  logic [AW-3:0] wadr [DEPTH],
  input  logic [PW-1:0] head,
  input  logic [PW:0]   count,
  output logic          hit,
  output logic [PW-1:0] idx
);

  logic [PW-1:0] p;

  // Walk oldest to youngest so the last match wins.
  always_comb begin
    hit = 1'b0;
    idx = head;
    p   = head;
    for (int k = 0; k < DEPTH; k++) begin
      p = head + PW'(k);
      if ((PW+1)'(k) < count && wadr[p] == key) begin
        hit = 1'b1;
        idx = p;
      end
    end
  end

endmodule

// File: rtl/store_write_buffer.sv
// Posted-store FIFO between the core data port and data memory,
// with youngest-first forwarding to loads.
module store_write_buffer
  import store_write_buffer_pkg::*;
#(
  parameter int DEPTH = SB_DEPTH,
  parameter int AW    = SB_AW,
  parameter int DW    = SB_DW,
  localparam int PW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          memwrite,
  input  logic          memread,
  input  logic [AW-1:0] dataadr,
  input  logic [DW-1:0] writedata,
  output logic [DW-1:0] readdata,
  output logic          stall,
  output logic          mem_we,
  output logic [AW-1:0] mem_adr,
  output logic [DW-1:0] mem_wd,
  input  logic          mem_ready,
  input  logic [DW-1:0] mem_rdata,
  output logic          empty
);

  sb_entry_t     fifo_q [DEPTH];
  logic [PW-1:0] head_q, tail_q;
  logic [PW:0]   count_q;

  logic [AW-3:0] wadr [DEPTH];
  logic          hit;
  logic [PW-1:0] hit_idx;
  logic          full, nonempty;
  logic          ld_miss, enq, deq;

  always_comb begin
    for (int i = 0; i < DEPTH; i++)
      wadr[i] = fifo_q[i].wadr;
  end

  sb_fwd_match #(.DEPTH(DEPTH), .AW(AW)) u_match (
    .key   (dataadr[AW-1:2]),
    .wadr  (wadr),
    .head  (head_q),
    .count (count_q),
    .hit   (hit),
    .idx   (hit_idx)
  );

  assign full     = (count_q == (PW+1)'(DEPTH));
  assign nonempty = (count_q != '0);

  // A load miss needs the memory port, so it pre-empts the drain.
  assign ld_miss = memread & nonempty & ~hit;

  always_comb begin
    empty    = ~nonempty | ~reset;
    stall    = reset & ((memwrite & full) | ld_miss);
    mem_we   = reset & nonempty & ~ld_miss;
    mem_adr  = mem_we ? {fifo_q[head_q].wadr, 2'b00} : dataadr;
    mem_wd   = fifo_q[head_q].data;
    readdata = '0;
    if (reset && memread)
      readdata = hit ? fifo_q[hit_idx].data : mem_rdata;
  end

  assign enq = memwrite & ~full & ~stall;
  assign deq = mem_we & mem_ready;

  always_ff @(posedge clk) begin
    if (!reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (enq) tail_q <= tail_q + 1'b1;
      if (deq) head_q <= head_q + 1'b1;
      if (enq && !deq)      count_q <= count_q + 1'b1;
      else if (deq && !enq) count_q <= count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset && enq)
      fifo_q[tail_q] <= '{wadr: dataadr[AW-1:2], data: writedata};
  end

endmodule

// File: tb/tb_store_write_buffer.sv
// Directed bench for store_write_buffer.
// Inputs change 1ns after posedge; outputs are checked mid-cycle.
module tb_store_write_buffer;

  logic        clk = 1'b0;
  logic        reset;
  logic        memwrite, memread;
  logic [31:0] dataadr, writedata;
  logic [31:0] readdata;
  logic        stall, mem_we, mem_ready, empty;
  logic [31:0] mem_adr, mem_wd, mem_rdata;

  int vecs = 0;
  int errs = 0;

  always #5 clk = ~clk;

  store_write_buffer dut (
    .clk       (clk),
    .reset     (reset),
    .memwrite  (memwrite),
    .memread   (memread),
    .dataadr   (dataadr),
    .writedata (writedata),
    .readdata  (readdata),
    .stall     (stall),
    .mem_we    (mem_we),
    .mem_adr   (mem_adr),
    .mem_wd    (mem_wd),
    .mem_ready (mem_ready),
    .mem_rdata (mem_rdata),
    .empty     (empty)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic st(input logic [31:0] a, input logic [31:0] d);
    memwrite  = 1'b1;
    dataadr   = a;
    writedata = d;
    step();
  endtask

  initial begin
    reset = 1'b0; memwrite = 1'b1; memread = 1'b0;
    dataadr = 32'd84; writedata = 32'd9;
    mem_ready = 1'b1; mem_rdata = 32'h0;

    // 1: reset with a store request held
    settle();
    chk("rst_stall", {31'b0, stall}, 32'd0);
    step(); step();
    chk("rst_empty", {31'b0, empty}, 32'd1);
    chk("rst_we", {31'b0, mem_we}, 32'd0);
    chk("rst_rd", readdata, 32'd0);
    memwrite = 1'b0; reset = 1'b1;
    step();
    chk("post_rst_empty", {31'b0, empty}, 32'd1);
    chk("post_rst_we", {31'b0, mem_we}, 32'd0);

    // 2: single store drains next cycle
    memwrite = 1'b1; dataadr = 32'd84; writedata = 32'd7;
    settle();
    chk("t2_same_we", {31'b0, mem_we}, 32'd0);
    step();
    memwrite = 1'b0; settle();
    chk("t2_we", {31'b0, mem_we}, 32'd1);
    chk("t2_adr", mem_adr, 32'd84);
    chk("t2_wd", mem_wd, 32'd7);
    step();
    chk("t2_empty", {31'b0, empty}, 32'd1);

    // 3: fill, stall, drain in order, retry
    mem_ready = 1'b0;
    st(32'd80, 32'd10); st(32'd84, 32'd11);
    st(32'd88, 32'd12); st(32'd92, 32'd13);
    memwrite = 1'b1; dataadr = 32'd96; writedata = 32'd14;
    settle();
    chk("t3_full_stall", {31'b0, stall}, 32'd1);
    chk("t3_head80", mem_adr, 32'd80);
    step();
    chk("t3_still_stall", {31'b0, stall}, 32'd1);
    mem_ready = 1'b1; settle();
    chk("t3_stall_on_drain", {31'b0, stall}, 32'd1);
    step();
    chk("t3_retry_ok", {31'b0, stall}, 32'd0);
    chk("t3_head84", mem_adr, 32'd84);
    step();
    memwrite = 1'b0; settle();
    chk("t3_head88", mem_adr, 32'd88);
    step();
    chk("t3_head92", mem_adr, 32'd92);
    step();
    chk("t3_head96", mem_adr, 32'd96);
    chk("t3_wd96", mem_wd, 32'd14);
    step();
    chk("t3_empty", {31'b0, empty}, 32'd1);

    // 4: youngest of two same-address stores forwards
    mem_ready = 1'b0;
    st(32'd84, 32'd5); st(32'd84, 32'd7);
    memwrite = 1'b0; memread = 1'b1;
    dataadr = 32'd84; mem_rdata = 32'hdead;
    settle();
    chk("t4_fwd", readdata, 32'd7);
    chk("t4_nostall", {31'b0, stall}, 32'd0);
    chk("t4_we", {31'b0, mem_we}, 32'd1);
    chk("t4_wd_old", mem_wd, 32'd5);
    memread = 1'b0; settle();
    chk("t4_rd_idle", readdata, 32'd0);
    mem_ready = 1'b1;
    step();
    chk("t4_wd_young", mem_wd, 32'd7);
    step();
    chk("t4_empty", {31'b0, empty}, 32'd1);

    // 5: load miss takes the port from the drain
    mem_ready = 1'b0;
    st(32'd80, 32'd1);
    memwrite = 1'b0; mem_ready = 1'b1; memread = 1'b1;
    dataadr = 32'd100; mem_rdata = 32'h55;
    settle();
    chk("t5_stall", {31'b0, stall}, 32'd1);
    chk("t5_we", {31'b0, mem_we}, 32'd0);
    chk("t5_adr", mem_adr, 32'd100);
    chk("t5_rd", readdata, 32'h55);
    step();
    memread = 1'b0; settle();
    chk("t5_resume_we", {31'b0, mem_we}, 32'd1);
    chk("t5_resume_adr", mem_adr, 32'd80);
    step();
    chk("t5_empty", {31'b0, empty}, 32'd1);

    // 6: reset discards pending entries
    mem_ready = 1'b0;
    st(32'd80, 32'd2); st(32'd84, 32'd3); st(32'd88, 32'd4);
    memwrite = 1'b0; settle();
    chk("t6_pending", {31'b0, empty}, 32'd0);
    reset = 1'b0; mem_ready = 1'b1; settle();
    chk("t6_we_gated", {31'b0, mem_we}, 32'd0);
    step();
    chk("t6_empty", {31'b0, empty}, 32'd1);
    reset = 1'b1;
    step();
    chk("t6_no_stale_we", {31'b0, mem_we}, 32'd0);
    chk("t6_empty_after", {31'b0, empty}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
